mem_stage: RTL and testbench

Memory-access pipeline stage that sits directly downstream of the execute stage. It consumes the ALU result, the memory address and the store data, runs a request/grant/response handshake with the data memory, and presents a single-cycle-valid write-back result to the register-file write stage. While a memory access is in flight, it back-pressures the pipeline through `in_ready` and `stall`.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_timeout_ctr.sv | 21 ++
 rtl/mem_stage.sv | 84 ++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, alignment mask and capture-register layout for the memory stage
package mem_pkg;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
    typedef struct packed {
        logic              read;
        logic              write;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_DW-1:0] alu;
    } mem_op_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: clear/enable cycle counter flagging when LIMIT-1 is reached
module mem_timeout_ctr
    import mem_pkg::*;
#(
    parameter int LIMIT = 255,
    parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == W'(LIMIT - 1);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with req/gnt/rvalid data-memory handshake and timeout
module mem_stage
    import mem_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] exeOut,
    input  logic [AW-1:0] addrOut,
    input  logic [DW-1:0] storeData,
    input  logic          memRead,
    input  logic          memWrite,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_gnt,
    input  logic          dm_rvalid,
    input  logic [DW-1:0] dm_rdata,
    output logic          out_valid,
    output logic [DW-1:0] memOut,
    output logic          mem_err,
    output logic          stall
);
    mem_state_t state, state_n;
    mem_op_t op;
    logic accept, is_mem, fault, legal, store_done, load_done, expired, timeout;
    logic out_valid_n, mem_err_n;
    logic [DW-1:0] wb_data;
    assign in_ready   = state == IDLE;
    assign stall      = !in_ready;
    assign accept     = in_valid && in_ready;
    assign is_mem     = memRead || memWrite;
    assign fault      = is_mem && (((addrOut[1:0] & ALIGN_MASK) != 2'b00) || (memRead && memWrite));
    assign legal      = is_mem && !fault;
    assign store_done = state == REQ && op.write && dm_gnt;
    assign load_done  = state == WAIT && dm_rvalid;
    // completion in the expiry cycle takes priority over the abort
    assign timeout    = state != IDLE && expired && !store_done && !load_done;
    assign dm_req     = state == REQ;
    assign dm_we      = dm_req && op.write;
    assign dm_addr    = dm_req ? AW'(op.addr) : '0;
    assign dm_wdata   = dm_req ? DW'(op.wdata) : '0;
    mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept && legal),
        .en      (state != IDLE),
        .expired (expired)
    );
    always_comb begin
        state_n = state == IDLE ? (accept && legal ? REQ : IDLE)
                : timeout       ? IDLE
                : state == REQ  ? (dm_gnt ? (op.write ? IDLE : WAIT) : REQ)
                :                 (dm_rvalid ? IDLE : WAIT);
        out_valid_n = (accept && !legal) || store_done || load_done || timeout;
        mem_err_n   = (accept && fault) || timeout;
        wb_data     = accept && !is_mem ? exeOut
                    : store_done        ? DW'(op.alu)
                    : load_done         ? dm_rdata
                    :                     '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            out_valid <= 1'b0;
            mem_err   <= 1'b0;
            memOut    <= '0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            mem_err   <= mem_err_n;
            if (accept) op <= '{read: memRead, write: memWrite, addr: MEM_AW'(addrOut),
                                wdata: MEM_DW'(storeData), alu: MEM_DW'(exeOut)};
            if (out_valid_n) memOut <= wb_data;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with TIMEOUT = 4
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, memRead, memWrite;
    logic [31:0] exeOut, addrOut, storeData, dm_addr, dm_wdata, dm_rdata, memOut;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, out_valid, mem_err, stall;
    int checks = 0;
    int errors = 0;
    mem_stage #(.DW(32), .AW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .exeOut(exeOut), .addrOut(addrOut), .storeData(storeData),
        .memRead(memRead), .memWrite(memWrite),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .memOut(memOut), .mem_err(mem_err), .stall(stall)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] alu);
        in_valid = 1'b1; memRead = rd; memWrite = wr; addrOut = a; storeData = sd; exeOut = alu;
    endtask
    task automatic idle_in();
        in_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        addrOut = 32'hFFFF_FFFF; storeData = 32'h0BAD_0BAD; exeOut = 32'h7777_7777;
    endtask
    initial begin
        rst_n = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        idle_in();
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst stall", stall, 0);
        chk("rst dm_req", dm_req, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst mem_err", mem_err, 0);
        chk("rst memOut", memOut, 0);
        rst_n = 1'b1;
        tick();
        // non-memory op
        issue(0, 0, 32'h0, 32'h0, 32'h0000_1234);
        tick();
        chk("alu out_valid", out_valid, 1);
        chk("alu memOut", memOut, 32'h1234);
        chk("alu mem_err", mem_err, 0);
        chk("alu in_ready", in_ready, 1);
        idle_in();
        tick();
        chk("alu pulse end", out_valid, 0);
        chk("alu memOut hold", memOut, 32'h1234);
        // store, grant in third REQ cycle
        issue(0, 1, 32'h100, 32'hDEAD_BEEF, 32'h55);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("st dm_req", dm_req, 1);
            chk("st dm_we", dm_we, 1);
            chk("st dm_addr", dm_addr, 32'h100);
            chk("st dm_wdata", dm_wdata, 32'hDEAD_BEEF);
            chk("st stall", stall, 1);
            chk("st in_ready", in_ready, 0);
            chk("st out_valid", out_valid, 0);
            dm_gnt = (i == 2);
            tick();
        end
        dm_gnt = 1'b0;
        chk("st out_valid", out_valid, 1);
        chk("st memOut", memOut, 32'h55);
        chk("st mem_err", mem_err, 0);
        chk("st dm_req drop", dm_req, 0);
        chk("st in_ready back", in_ready, 1);
        tick();
        chk("st pulse end", out_valid, 0);
        // load, immediate grant, rvalid two cycles after grant
        issue(1, 0, 32'h200, 32'h0, 32'h99);
        tick();
        idle_in();
        chk("ld dm_req", dm_req, 1);
        chk("ld dm_we", dm_we, 0);
        chk("ld dm_addr", dm_addr, 32'h200);
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        chk("ld wait dm_req", dm_req, 0);
        chk("ld wait stall", stall, 1);
        tick();
        chk("ld wait out_valid", out_valid, 0);
        dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        tick();
        dm_rvalid = 1'b0; dm_rdata = 32'h0;
        chk("ld out_valid", out_valid, 1);
        chk("ld memOut", memOut, 32'hCAFE_F00D);
        chk("ld mem_err", mem_err, 0);
        chk("ld in_ready", in_ready, 1);
        tick();
        chk("ld pulse end", out_valid, 0);
        chk("ld memOut hold", memOut, 32'hCAFE_F00D);
        // misaligned load then illegal read+write, back to back
        issue(1, 0, 32'h203, 32'h0, 32'h11);
        chk("mis no req", dm_req, 0);
        tick();
        chk("mis out_valid", out_valid, 1);
        chk("mis mem_err", mem_err, 0 + 1);
        chk("mis memOut", memOut, 0);
        chk("mis in_ready", in_ready, 1);
        chk("mis dm_req", dm_req, 0);
        issue(1, 1, 32'h300, 32'h0, 32'h22);
        tick();
        chk("ill out_valid", out_valid, 1);
        chk("ill mem_err", mem_err, 1);
        chk("ill memOut", memOut, 0);
        chk("ill dm_req", dm_req, 0);
        idle_in();
        tick();
        chk("ill pulse end", out_valid, 0);
        chk("ill err end", mem_err, 0);
        // timeout: granted load, rvalid never arrives
        issue(1, 0, 32'h400, 32'h0, 32'h33);
        tick();
        idle_in();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        tick();
        chk("to waiting", in_ready, 0);
        tick();
        chk("to last wait", in_ready, 0);
        chk("to no early pulse", out_valid, 0);
        tick();
        chk("to out_valid", out_valid, 1);
        chk("to mem_err", mem_err, 1);
        chk("to memOut", memOut, 0);
        chk("to in_ready", in_ready, 1);
        dm_rvalid = 1'b1; dm_rdata = 32'h1111;
        tick();
        dm_rvalid = 1'b0;
        chk("stray out_valid", out_valid, 0);
        chk("stray mem_err", mem_err, 0);
        chk("stray memOut", memOut, 0);
        chk("stray in_ready", in_ready, 1);
        // rvalid in the expiry cycle: completion wins
        issue(1, 0, 32'h500, 32'h0, 32'h44);
        tick();
        idle_in();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        tick();
        tick();
        dm_rvalid = 1'b1; dm_rdata = 32'hABCD;
        tick();
        dm_rvalid = 1'b0;
        chk("edge out_valid", out_valid, 1);
        chk("edge mem_err", mem_err, 0);
        chk("edge memOut", memOut, 32'hABCD);
        tick();
        // async reset while in REQ drops dm_req at once
        issue(0, 1, 32'h600, 32'h5, 32'h66);
        tick();
        idle_in();
        chk("rq dm_req", dm_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rq rst dm_req", dm_req, 0);
        chk("rq rst in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        // async reset while in WAIT, late rvalid ignored
        issue(1, 0, 32'h700, 32'h0, 32'h77);
        tick();
        idle_in();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        chk("wt stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("wt rst dm_req", dm_req, 0);
        chk("wt rst out_valid", out_valid, 0);
        chk("wt rst in_ready", in_ready, 1);
        chk("wt rst stall", stall, 0);
        rst_n = 1'b1;
        dm_rvalid = 1'b1; dm_rdata = 32'h2222;
        tick();
        dm_rvalid = 1'b0;
        chk("late rvalid ignored", out_valid, 0);
        // async reset clears a live out_valid pulse
        issue(0, 0, 32'h0, 32'h0, 32'h8888);
        tick();
        idle_in();
        chk("post-rst alu out_valid", out_valid, 1);
        chk("post-rst alu memOut", memOut, 32'h8888);
        rst_n = 1'b0;
        #1;
        chk("ov rst out_valid", out_valid, 0);
        chk("ov rst memOut", memOut, 0);
        rst_n = 1'b1;
        tick();
        // normal store after reset
        issue(0, 1, 32'h804, 32'h1357, 32'h2468);
        tick();
        idle_in();
        chk("fin dm_addr", dm_addr, 32'h804);
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        chk("fin out_valid", out_valid, 1);
        chk("fin memOut", memOut, 32'h2468);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
